// File: rtl/poly_tone_gen.sv
// Multi-key square-wave tone generator: per-key sync/debounce, runtime half-periods,
// mono lowest-index priority or poly PWM mix onto a single speaker pin.
module poly_tone_gen #(
    parameter int NUM_KEYS   = 5,
    parameter int CNT_W      = 21,
    parameter int DEB_CYCLES = 1000000,
    parameter int IDX_W      = $clog2(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                mode,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_addr,
    input  logic [CNT_W-1:0]    cfg_data,
    output logic                speaker,
    output logic                note_valid,
    output logic [IDX_W-1:0]    note_idx,
    output logic [NUM_KEYS-1:0] active_keys
);
    localparam int DEB_W = $clog2(DEB_CYCLES) + 1;
    localparam int LVL_W = $clog2(NUM_KEYS + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [IDX_W-1:0] P_LAST   = IDX_W'(NUM_KEYS - 1);

    logic [NUM_KEYS-1:0] deb;
    logic [NUM_KEYS-1:0] sq;
    logic [NUM_KEYS-1:0] en;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            logic [1:0]       sync_reg;
            logic [DEB_W-1:0] deb_cnt_reg;
            logic             deb_reg;
            logic [CNT_W-1:0] hp_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             sq_reg;
            logic             write_hit;

            assign write_hit = cfg_we && (cfg_addr == IDX_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg    <= '0;
                    deb_cnt_reg <= '0;
                    deb_reg     <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[0], keys[gi]};
                    if (sync_reg[1] == deb_reg) begin
                        deb_cnt_reg <= '0;
                    end else if (deb_cnt_reg == DEB_LAST) begin
                        deb_cnt_reg <= '0;
                        deb_reg     <= sync_reg[1];
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
                    end
                end
            end

            // A config write restarts the channel phase and wins over a same-cycle toggle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hp_reg  <= '0;
                    cnt_reg <= '0;
                    sq_reg  <= 1'b0;
                end else if (write_hit) begin
                    hp_reg  <= cfg_data;
                    cnt_reg <= '0;
                    sq_reg  <= 1'b0;
                end else if (hp_reg == '0) begin
                    cnt_reg <= '0;
                    sq_reg  <= 1'b0;
                end else if (cnt_reg == hp_reg - CNT_W'(1)) begin
                    cnt_reg <= '0;
                    sq_reg  <= ~sq_reg;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign deb[gi] = deb_reg;
            assign sq[gi]  = sq_reg;
            assign en[gi]  = deb_reg && (hp_reg != '0);
        end
    endgenerate

    logic [IDX_W-1:0] sel;
    logic             mono_bit;
    logic [LVL_W-1:0] lit_count;

    always_comb begin
        sel       = '0;
        mono_bit  = 1'b0;
        lit_count = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (en[i]) begin
                sel      = IDX_W'(i);
                mono_bit = sq[i];
            end
        end
        for (int i = 0; i < NUM_KEYS; i++) begin
            lit_count = lit_count + LVL_W'(en[i] & sq[i]);
        end
    end

    logic                speaker_reg;
    logic                note_valid_reg;
    logic [IDX_W-1:0]    note_idx_reg;
    logic [NUM_KEYS-1:0] active_keys_reg;
    logic                mode_reg;
    logic [IDX_W-1:0]    p_reg;
    logic [LVL_W-1:0]    level_reg;

    // The speaker follows the registered mode, so a new mode takes over one cycle after it changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speaker_reg     <= 1'b0;
            note_valid_reg  <= 1'b0;
            note_idx_reg    <= '0;
            active_keys_reg <= '0;
            mode_reg        <= 1'b0;
            p_reg           <= '0;
            level_reg       <= '0;
        end else begin
            active_keys_reg <= en;
            note_valid_reg  <= |en;
            note_idx_reg    <= sel;
            speaker_reg     <= mode_reg ? (LVL_W'(p_reg) < level_reg) : mono_bit;
            if (mode != mode_reg) begin
                mode_reg  <= mode;
                p_reg     <= '0;
                level_reg <= '0;
            end else begin
                p_reg <= (p_reg == P_LAST) ? '0 : p_reg + IDX_W'(1);
                if (p_reg == '0) begin
                    level_reg <= lit_count;
                end
            end
        end
    end

    assign speaker     = speaker_reg;
    assign note_valid  = note_valid_reg;
    assign note_idx    = note_idx_reg;
    assign active_keys = active_keys_reg;
endmodule

// File: tb/tb_poly_tone_gen.sv
// Randomised bench for poly_tone_gen against a closed-form reference model
// (phase from write time, debounce from key history, PWM frame from frame start).
module tb_poly_tone_gen;
    localparam int N   = 5;
    localparam int CW  = 21;
    localparam int DEB = 4;
    localparam int IW  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  keys;
    logic          mode;
    logic          cfg_we;
    logic [IW-1:0] cfg_addr;
    logic [CW-1:0] cfg_data;
    logic          speaker;
    logic          note_valid;
    logic [IW-1:0] note_idx;
    logic [N-1:0]  active_keys;

    always #5 clk = ~clk;

    poly_tone_gen #(.NUM_KEYS(N), .CNT_W(CW), .DEB_CYCLES(DEB), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .keys(keys), .mode(mode),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .speaker(speaker), .note_valid(note_valid), .note_idx(note_idx),
        .active_keys(active_keys)
    );

    // Reference model state
    logic [CW-1:0] hp_m [N];
    longint        wr_m [N];
    longint        e;
    longint        fs;
    logic [N-1:0]  deb_m;
    logic [N-1:0]  kh [8];
    logic          mode_m;
    int            level_m;
    logic          exp_spk;
    logic          exp_nv;
    logic [IW-1:0] exp_idx;
    logic [N-1:0]  exp_act;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, got, exp);
        end
    endtask

    function automatic logic sq_at(input int i, input longint t);
        if (hp_m[i] == '0) return 1'b0;
        return logic'(((t - wr_m[i]) / longint'(hp_m[i])) % 2);
    endfunction

    function automatic logic kh_bit(input longint idx, input int b);
        if (idx < 1) return 1'b0;
        return kh[int'(idx % 8)][b];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            hp_m[i] = '0;
            wr_m[i] = 0;
        end
        for (int i = 0; i < 8; i++) kh[i] = '0;
        e = 0; fs = 0; deb_m = '0; mode_m = 1'b0; level_m = 0;
        exp_spk = 1'b0; exp_nv = 1'b0; exp_idx = '0; exp_act = '0;
    endtask

    // Advance the model by one rising edge using the inputs presented before it.
    task automatic model_step();
        logic [N-1:0] sq_m, en_m, deb_nx;
        logic         mono, flip;
        int           p_pre;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e++;
        for (int i = 0; i < N; i++) begin
            sq_m[i] = sq_at(i, e - 1);
            en_m[i] = deb_m[i] && (hp_m[i] != '0);
        end
        p_pre = int'((e - 1 - fs) % N);
        mono = 1'b0;
        exp_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (en_m[i]) begin
                mono = sq_m[i];
                exp_idx = IW'(i);
            end
        end
        exp_act = en_m;
        exp_nv  = |en_m;
        exp_spk = mode_m ? (p_pre < level_m) : mono;
        if (mode != mode_m) begin
            mode_m = mode; fs = e; level_m = 0;
        end else if (p_pre == 0) begin
            level_m = $countones(en_m & sq_m);
        end
        for (int b = 0; b < N; b++) begin
            flip = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                if (kh_bit(e - 2 - j, b) == deb_m[b]) flip = 1'b0;
            end
            deb_nx[b] = flip ? ~deb_m[b] : deb_m[b];
        end
        deb_m = deb_nx;
        kh[int'(e % 8)] = keys;
        if (cfg_we && (int'(cfg_addr) < N)) begin
            hp_m[cfg_addr] = cfg_data;
            wr_m[cfg_addr] = e;
        end
    endtask

    task automatic check_outputs();
        check("speaker", 32'(speaker), 32'(exp_spk));
        check("note_valid", 32'(note_valid), 32'(exp_nv));
        check("note_idx", 32'(note_idx), 32'(exp_idx));
        check("active_keys", 32'(active_keys), 32'(exp_act));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_hp(input int addr, input int data);
        cfg_we = 1'b1;
        cfg_addr = IW'(addr);
        cfg_data = CW'(data);
        $display("cfg write addr=%0d data=%0d edge=%0d", addr, data, e + 1);
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic run_rand(input int cycles, input int key_p, input int we_p,
                            input int mode_p, input int hp_max);
        int b;
        for (int c = 0; c < cycles; c++) begin
            b = int'($urandom_range(N - 1));
            if ($urandom_range(99) < key_p) keys[b] = ~keys[b];
            if ($urandom_range(999) < mode_p) mode = ~mode;
            cfg_we   = ($urandom_range(99) < we_p);
            cfg_addr = IW'($urandom_range(7));
            cfg_data = CW'($urandom_range(hp_max));
            if (cfg_we)
                $display("cfg write addr=%0d data=%0d edge=%0d", cfg_addr, cfg_data, e + 1);
            cycle();
        end
        cfg_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; keys = '1; mode = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        model_reset();
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (12) cycle();

        // Mono tone, priority, disabled channel, out-of-range address
        keys = '0;
        set_hp(0, 3); set_hp(1, 5); set_hp(3, 2); set_hp(2, 0); set_hp(6, 9);
        keys = 5'b00001; repeat (30) cycle();
        keys = 5'b01010; repeat (40) cycle();
        keys = 5'b01000; repeat (30) cycle();
        keys = 5'b00100; repeat (20) cycle();
        // Short glitch then a long hold on key 0
        keys = 5'b00001; repeat (3) cycle();
        keys = 5'b00000; repeat (10) cycle();
        keys = 5'b00001; repeat (20) cycle();

        run_rand(1500, 8, 3, 0, 7);

        // Poly PWM with every channel at hp=1000
        keys = '0; mode = 1'b1;
        for (int i = 0; i < N; i++) set_hp(i, 1000);
        keys = '1; repeat (2500) cycle();
        keys = 5'b00011; repeat (1200) cycle();
        mode = 1'b0; repeat (10) cycle();
        mode = 1'b1; repeat (30) cycle();

        run_rand(3000, 6, 2, 3, 12);

        // Asynchronous reset mid-operation
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        repeat (2) cycle();
        rst_n = 1'b1;
        run_rand(1000, 8, 4, 4, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
